// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the master and the register bank.
// Ports: psel/penable/pwrite/paddr/pwdata/pstrb in, pready/prdata/pslverr back.
interface apb_slave_regbank_if;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [1:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  modport master (
    output psel, penable, pwrite,
    output paddr, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite,
    input  paddr, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer register bank: ID word + R/W words, halfword strobes, wait states.
// Ports: pclk, prst (sync, active-high), apb (slave modport of the bus bundle).
module apb_slave_regbank #(
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                  pclk,
  input  logic                  prst,
  apb_slave_regbank_if.slave    apb
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [3:0] WC = 4'(WAIT_CYCLES);
  localparam logic [4:0] NR = 5'(NUM_REGS);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic [31:0] regs_q [1:NUM_REGS-1];
  logic [31:0] regs_d [1:NUM_REGS-1];

  logic        access;
  logic        done;
  logic        hit;
  logic [3:0]  idx;
  logic [31:0] rd_word;
  logic        unused_addr;

  assign unused_addr = ^apb.paddr[1:0];

  assign access = apb.psel & apb.penable;
  assign idx    = apb.paddr[5:2];
  assign hit    = (apb.paddr[31:6] == BASE_ADDR[31:6])
                & ({1'b0, idx} < NR);

  always_comb begin
    rd_word = ID_VALUE;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (idx == 4'(i)) rd_word = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    regs_d    = regs_q;
    done      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (access) begin
          if (WAIT_CYCLES == 0) begin
            done = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
      end
      S_WAIT: begin
        // master withdrew mid-ACCESS: drop it silently
        if (!access) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == WC) begin
          done = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        // one dead cycle so the next SETUP is not taken as ACCESS
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (done) begin
      state_d  = S_RESP;
      cnt_d    = 4'd0;
      pready_d = 1'b1;
      if (!hit || (apb.pwrite && idx == 4'd0)) begin
        pslverr_d = 1'b1;
        if (!apb.pwrite) prdata_d = 32'h0;
      end else if (apb.pwrite) begin
        for (int i = 1; i < NUM_REGS; i++) begin
          if (idx == 4'(i)) begin
            if (apb.pstrb[0])
              regs_d[i][15:0] = apb.pwdata[15:0];
            if (apb.pstrb[1])
              regs_d[i][31:16] = apb.pwdata[31:16];
          end
        end
      end else begin
        prdata_d = rd_word;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= 32'h0;
      for (int i = 1; i < NUM_REGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      regs_q    <= regs_d;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: 2-wait and 0-wait builds.
// Drives one APB master model muxed onto either bank.
module tb_apb_slave_regbank;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  apb_slave_regbank_if bus_a ();
  apb_slave_regbank_if bus_b ();

  apb_slave_regbank #(.WAIT_CYCLES(2)) u_dut_a (
    .pclk (pclk),
    .prst (prst),
    .apb  (bus_a)
  );

  apb_slave_regbank #(.WAIT_CYCLES(0)) u_dut_b (
    .pclk (pclk),
    .prst (prst),
    .apb  (bus_b)
  );

  logic        which = 1'b0;
  logic        m_psel = 1'b0;
  logic        m_penable = 1'b0;
  logic        m_pwrite = 1'b0;
  logic [31:0] m_paddr = '0;
  logic [31:0] m_pwdata = '0;
  logic [1:0]  m_pstrb = '0;

  assign bus_a.psel    = which ? 1'b0 : m_psel;
  assign bus_a.penable = which ? 1'b0 : m_penable;
  assign bus_a.pwrite  = m_pwrite;
  assign bus_a.paddr   = m_paddr;
  assign bus_a.pwdata  = m_pwdata;
  assign bus_a.pstrb   = m_pstrb;
  assign bus_b.psel    = which ? m_psel : 1'b0;
  assign bus_b.penable = which ? m_penable : 1'b0;
  assign bus_b.pwrite  = m_pwrite;
  assign bus_b.paddr   = m_paddr;
  assign bus_b.pwdata  = m_pwdata;
  assign bus_b.pstrb   = m_pstrb;

  logic        s_pready;
  logic [31:0] s_prdata;
  logic        s_pslverr;
  assign s_pready  = which ? bus_b.pready  : bus_a.pready;
  assign s_prdata  = which ? bus_b.prdata  : bus_a.prdata;
  assign s_pslverr = which ? bus_b.pslverr : bus_a.pslverr;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic        b,
                      input logic        wr,
                      input logic [31:0] addr,
                      input logic [31:0] wdata,
                      input logic [1:0]  strb,
                      output logic [31:0] rd,
                      output logic        err);
    int lat;
    bit got;
    which = b;
    @(posedge pclk); #1;
    m_psel = 1'b1; m_penable = 1'b0;
    m_pwrite = wr; m_paddr = addr;
    m_pwdata = wdata; m_pstrb = strb;
    @(posedge pclk); #1;
    chk("setup_rdy", 32'(s_pready), 32'd0);
    m_penable = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(posedge pclk); #1;
      lat++;
      if (s_pready) got = 1'b1;
    end
    chk("latency", 32'(lat), b ? 32'd1 : 32'd3);
    rd  = s_prdata;
    err = s_pslverr;
    m_psel = 1'b0; m_penable = 1'b0;
    @(posedge pclk); #1;
    chk("rdy_pulse", 32'(s_pready), 32'd0);
  endtask

  logic [31:0] rd;
  logic        err;

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    chk("rst_rdy", 32'(bus_a.pready), 32'd0);
    chk("rst_rdata", bus_a.prdata, 32'd0);
    chk("rst_err", 32'(bus_a.pslverr), 32'd0);
    prst = 1'b0;

    xfer(0, 0, 32'h0, 0, 2'b00, rd, err);
    chk("id_rd", rd, 32'hA5B0_0001);
    chk("id_err", 32'(err), 32'd0);
    xfer(0, 0, 32'hC, 0, 2'b00, rd, err);
    chk("r3_rst", rd, 32'h0);

    xfer(0, 1, 32'hC, 32'hDEAD_BEEF, 2'b11, rd, err);
    chk("w3_err", 32'(err), 32'd0);
    chk("w_keeps_rdata", rd, 32'h0);
    xfer(0, 0, 32'hC, 0, 2'b00, rd, err);
    chk("r3", rd, 32'hDEAD_BEEF);

    xfer(0, 1, 32'h10, 32'h1111_2222, 2'b11, rd, err);
    xfer(0, 1, 32'h10, 32'hAAAA_BBBB, 2'b01, rd, err);
    xfer(0, 0, 32'h10, 0, 2'b00, rd, err);
    chk("strb01", rd, 32'h1111_BBBB);
    xfer(0, 1, 32'h10, 32'hAAAA_BBBB, 2'b10, rd, err);
    xfer(0, 0, 32'h10, 0, 2'b00, rd, err);
    chk("strb10", rd, 32'hAAAA_BBBB);
    xfer(0, 1, 32'h10, 32'h5555_6666, 2'b00, rd, err);
    chk("strb00_err", 32'(err), 32'd0);
    xfer(0, 0, 32'h10, 0, 2'b00, rd, err);
    chk("strb00", rd, 32'hAAAA_BBBB);

    xfer(0, 1, 32'h0, 32'h0BAD_0BAD, 2'b11, rd, err);
    chk("w_id_err", 32'(err), 32'd1);
    xfer(0, 0, 32'h0, 0, 2'b00, rd, err);
    chk("id_keep", rd, 32'hA5B0_0001);
    chk("id_keep_err", 32'(err), 32'd0);
    xfer(0, 0, 32'h40, 0, 2'b00, rd, err);
    chk("miss_err", 32'(err), 32'd1);
    chk("miss_rd", rd, 32'h0);
    xfer(0, 1, 32'h44, 32'h1, 2'b11, rd, err);
    chk("wmiss_err", 32'(err), 32'd1);
    xfer(0, 0, 32'hC, 0, 2'b00, rd, err);
    chk("good_err", 32'(err), 32'd0);
    chk("good_rd", rd, 32'hDEAD_BEEF);

    xfer(1, 1, 32'h4, 32'h0000_0011, 2'b11, rd, err);
    xfer(1, 1, 32'h8, 32'h0000_0022, 2'b11, rd, err);
    xfer(1, 0, 32'h4, 0, 2'b00, rd, err);
    chk("w0_r1", rd, 32'h0000_0011);
    xfer(1, 0, 32'h8, 0, 2'b00, rd, err);
    chk("w0_r2", rd, 32'h0000_0022);
    chk("w0_err", 32'(err), 32'd0);

    xfer(0, 1, 32'h14, 32'hCAFE_0005, 2'b11, rd, err);
    which = 1'b0;
    @(posedge pclk); #1;
    m_psel = 1'b1; m_penable = 1'b0;
    m_pwrite = 1'b1; m_paddr = 32'h14;
    m_pwdata = 32'h1234_5678; m_pstrb = 2'b11;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #1;
    m_psel = 1'b0; m_penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge pclk); #1;
      chk("abort_rdy", 32'(bus_a.pready), 32'd0);
    end
    xfer(0, 0, 32'h14, 0, 2'b00, rd, err);
    chk("abort_r5", rd, 32'hCAFE_0005);

    @(posedge pclk); #1;
    m_psel = 1'b1; m_penable = 1'b0;
    m_pwrite = 1'b1; m_paddr = 32'h14;
    m_pwdata = 32'h1234_5678; m_pstrb = 2'b11;
    @(posedge pclk); #1;
    m_penable = 1'b1;
    @(posedge pclk); #1;
    prst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge pclk); #1;
      chk("rst_mid_rdy", 32'(bus_a.pready), 32'd0);
    end
    m_psel = 1'b0; m_penable = 1'b0;
    prst = 1'b0;
    xfer(0, 0, 32'h14, 0, 2'b00, rd, err);
    chk("rst_mid_r5", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
